// File: rtl/t5_fetch.sv
// Barrel-threaded instruction fetch for 4 harts with branch redirect and kill.
// Ports: sclk/srst, hena, bra/bpc in; iack in; istb/iadr/fpc/sena out.
module t5_fetch #(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            sclk,
    input  logic            srst,
    input  logic [3:0]      hena,
    input  logic            bra,
    input  logic [XLEN-1:0] bpc,
    input  logic            iack,
    output logic            istb,
    output logic [XLEN-1:0] iadr,
    output logic [XLEN-1:0] fpc,
    output logic            sena
);

    typedef enum logic {IDLE, FETCH} state_t;

    localparam int PW = XLEN - 2;

    state_t          r_state, w_state_nxt;
    logic [PW-1:0]   r_pc [4];
    logic [PW-1:0]   w_pc_nxt [4];
    logic [PW-1:0]   r_adr, w_adr_nxt;
    logic [1:0]      r_hptr, w_hptr_nxt;
    logic            r_kill, w_kill_nxt;
    logic [1:0]      w_bh;
    logic            w_hit;
    logic            w_ack;
    logic [1:0]      w_pick;

    // First enabled hart scanning base, base+1, base+2, base+3 (mod 4).
    function automatic logic [1:0] pick(input logic [3:0] en,
                                        input logic [1:0] base);
        logic [1:0] k;
        pick = base;
        for (int i = 3; i >= 0; i--) begin
            k = base + 2'(i);
            if (en[k]) pick = k;
        end
    endfunction

    assign w_bh  = bpc[1:0];
    assign w_ack = (r_state == FETCH) && iack;
    // Redirect aimed at the hart whose word is in flight.
    assign w_hit = bra && (r_state == FETCH) && (w_bh == r_hptr);

    assign istb = (r_state == FETCH);
    assign iadr = istb ? {r_adr, 2'b00} : '0;
    assign fpc  = {iadr[XLEN-1:2], r_hptr};
    assign sena = w_ack && !r_kill && !w_hit;

    // A killed word must not advance its PC: the redirect already set it.
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            w_pc_nxt[n] = r_pc[n];
            if (bra && (w_bh == 2'(n)))
                w_pc_nxt[n] = bpc[XLEN-1:2];
            else if (w_ack && !r_kill && (r_hptr == 2'(n)))
                w_pc_nxt[n] = r_pc[n] + 1'b1;
        end
    end

    assign w_pick = (r_state == IDLE) ? pick(hena, 2'd0)
                                      : pick(hena, r_hptr + 2'd1);

    always_comb begin
        w_state_nxt = r_state;
        w_hptr_nxt  = r_hptr;
        w_adr_nxt   = r_adr;
        w_kill_nxt  = r_kill;
        unique case (r_state)
            IDLE: begin
                w_kill_nxt = 1'b0;
                if (hena != 4'd0) begin
                    w_state_nxt = FETCH;
                    w_hptr_nxt  = w_pick;
                    w_adr_nxt   = w_pc_nxt[w_pick];
                end
            end
            FETCH: begin
                if (iack) begin
                    w_kill_nxt = 1'b0;
                    if (hena == 4'd0) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_hptr_nxt = w_pick;
                        w_adr_nxt  = w_pc_nxt[w_pick];
                    end
                end else if (w_hit) begin
                    w_kill_nxt = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sclk or negedge srst) begin
        if (!srst) begin
            r_state <= IDLE;
            r_hptr  <= 2'd0;
            r_kill  <= 1'b0;
            r_adr   <= '0;
            for (int n = 0; n < 4; n++)
                r_pc[n] <= RESET_PC[XLEN-1:2];
        end else begin
            r_state <= w_state_nxt;
            r_hptr  <= w_hptr_nxt;
            r_kill  <= w_kill_nxt;
            r_adr   <= w_adr_nxt;
            for (int n = 0; n < 4; n++)
                r_pc[n] <= w_pc_nxt[n];
        end
    end

endmodule

// File: tb/tb_t5_fetch.sv
// Directed bench for t5_fetch: round-robin, stalls, redirects, kill,
// hart enables and asynchronous reset.
module tb_t5_fetch;

    logic        sclk = 1'b0;
    logic        srst;
    logic [3:0]  hena;
    logic        bra;
    logic [31:0] bpc;
    logic        iack;
    logic        istb;
    logic [31:0] iadr;
    logic [31:0] fpc;
    logic        sena;

    int checks   = 0;
    int failures = 0;

    t5_fetch #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .sclk (sclk),
        .srst (srst),
        .hena (hena),
        .bra  (bra),
        .bpc  (bpc),
        .iack (iack),
        .istb (istb),
        .iadr (iadr),
        .fpc  (fpc),
        .sena (sena)
    );

    always #5 sclk = ~sclk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge sclk);
        #1;
    endtask

    // Expect an in-flight word; sample a little after inputs settle.
    task automatic word(input string tag, input logic [31:0] a,
                        input logic [31:0] f, input logic s);
        #1;
        chk({tag, ".istb"}, 32'(istb), 32'd1);
        chk({tag, ".iadr"}, iadr, a);
        chk({tag, ".fpc"}, fpc, f);
        chk({tag, ".sena"}, 32'(sena), 32'(s));
    endtask

    initial begin
        srst = 1'b0;
        hena = 4'h0;
        bra  = 1'b0;
        bpc  = 32'h0;
        iack = 1'b0;
        #2;
        chk("rst.istb", 32'(istb), 32'd0);
        chk("rst.iadr", iadr, 32'h0);
        chk("rst.fpc", fpc, 32'h0);
        chk("rst.sena", 32'(sena), 32'd0);
        cyc();
        cyc();
        srst = 1'b1;

        // 1: all harts, iack tied high
        hena = 4'hF;
        iack = 1'b1;
        #1;
        chk("t1.idle", 32'(istb), 32'd0);
        chk("t1.idle_sena", 32'(sena), 32'd0);
        cyc();
        for (int k = 0; k < 8; k++) begin
            word("t1", 32'((k / 4) * 4), 32'(k), 1'b1);
            cyc();
        end

        // 2: stall hart1 for two cycles
        word("t2.h0", 32'h8, 32'h8, 1'b1);
        cyc();
        iack = 1'b0;
        word("t2.w0", 32'h8, 32'h9, 1'b0);
        cyc();
        word("t2.w1", 32'h8, 32'h9, 1'b0);
        cyc();
        iack = 1'b1;
        word("t2.ack", 32'h8, 32'h9, 1'b1);
        cyc();
        word("t2.h2", 32'h8, 32'hA, 1'b1);
        cyc();
        word("t2.h3", 32'h8, 32'hB, 1'b1);
        cyc();

        // 3: redirect hart2 while hart0 is in flight
        bra = 1'b1;
        bpc = 32'h102;
        word("t3.h0", 32'hC, 32'hC, 1'b1);
        cyc();
        bra = 1'b0;
        word("t3.h1", 32'hC, 32'hD, 1'b1);
        cyc();
        word("t3.h2", 32'h100, 32'h102, 1'b1);
        cyc();
        word("t3.h3", 32'hC, 32'hF, 1'b1);
        cyc();
        word("t3.h0b", 32'h10, 32'h10, 1'b1);
        cyc();
        word("t3.h1b", 32'h10, 32'h11, 1'b1);
        cyc();
        word("t3.h2b", 32'h104, 32'h106, 1'b1);
        cyc();

        // 4: redirect hart1 while it waits; its ack is killed
        word("t4.h3", 32'h10, 32'h13, 1'b1);
        cyc();
        word("t4.h0", 32'h14, 32'h14, 1'b1);
        cyc();
        iack = 1'b0;
        bra  = 1'b1;
        bpc  = 32'h201;
        word("t4.wait", 32'h14, 32'h15, 1'b0);
        cyc();
        bra  = 1'b0;
        iack = 1'b1;
        word("t4.kill", 32'h14, 32'h15, 1'b0);
        cyc();
        word("t4.h2", 32'h108, 32'h10A, 1'b1);
        cyc();
        word("t4.h3b", 32'h14, 32'h17, 1'b1);
        cyc();
        word("t4.h0b", 32'h18, 32'h18, 1'b1);
        cyc();
        word("t4.h1", 32'h200, 32'h201, 1'b1);
        cyc();

        // same-cycle redirect of the acked hart
        bra = 1'b1;
        bpc = 32'h302;
        word("t4.hit", 32'h10C, 32'h10E, 1'b0);
        cyc();
        bra = 1'b0;
        word("t4.h3c", 32'h18, 32'h1B, 1'b1);
        cyc();
        word("t4.h0c", 32'h1C, 32'h1C, 1'b1);
        cyc();
        word("t4.h1c", 32'h204, 32'h205, 1'b1);
        cyc();
        word("t4.h2c", 32'h300, 32'h302, 1'b1);
        cyc();

        // 5: harts 0 and 2 only, then none, then hart 3
        hena = 4'b0101;
        word("t5.h3", 32'h1C, 32'h1F, 1'b1);
        cyc();
        word("t5.a0", 32'h20, 32'h20, 1'b1);
        cyc();
        word("t5.a2", 32'h304, 32'h306, 1'b1);
        cyc();
        word("t5.b0", 32'h24, 32'h24, 1'b1);
        cyc();
        hena = 4'h0;
        word("t5.b2", 32'h308, 32'h30A, 1'b1);
        cyc();
        #1;
        chk("t5.off", 32'(istb), 32'd0);
        chk("t5.off_sena", 32'(sena), 32'd0);
        cyc();
        hena = 4'b1000;
        #1;
        chk("t5.idle2", 32'(istb), 32'd0);
        cyc();
        bra = 1'b1;
        bpc = 32'h401;
        word("t5.h3a", 32'h20, 32'h23, 1'b1);
        cyc();
        bra = 1'b0;
        word("t5.h3b", 32'h24, 32'h27, 1'b1);
        cyc();
        hena = 4'b1010;
        word("t5.h3c", 32'h28, 32'h2B, 1'b1);
        cyc();
        word("t5.h1", 32'h400, 32'h401, 1'b1);
        cyc();

        // 6: reset in the middle of a stalled request
        iack = 1'b0;
        word("t6.wait", 32'h2C, 32'h2F, 1'b0);
        srst = 1'b0;
        #1;
        chk("t6.istb", 32'(istb), 32'd0);
        chk("t6.iadr", iadr, 32'h0);
        chk("t6.sena", 32'(sena), 32'd0);
        iack = 1'b1;
        cyc();
        srst = 1'b1;
        hena = 4'h0;
        #1;
        chk("t6.late", 32'(sena), 32'd0);
        chk("t6.idle", 32'(istb), 32'd0);
        cyc();
        hena = 4'hF;
        cyc();
        word("t6.h0", 32'h0, 32'h0, 1'b1);
        cyc();
        word("t6.h1", 32'h0, 32'h1, 1'b1);
        cyc();
        word("t6.h2", 32'h0, 32'h2, 1'b1);
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
